// File: rtl/lii_rx_demux_if.sv
// LII receive demux bundle: one tagged phy input channel, NOUT kernel streams.
// slave = demux side, master = fabric/kernel side driving beats and readies.
interface lii_rx_demux_if #(
   parameter int PW   = 128,
   parameter int NOUT = 2
);
   logic [PW-1:0]     lii_in_p0_tdata;
   logic              lii_in_p0_tvalid;
   logic              lii_in_p0_tready;
   logic [7:0]        lii_in_p0_src;
   logic [7:0]        lii_in_p0_dst;
   logic [NOUT*PW-1:0] out_tdata;
   logic [NOUT-1:0]   out_tvalid;
   logic [NOUT-1:0]   out_tready;
   logic [NOUT*8-1:0] out_src;
   logic [15:0]       drop_cnt;

   modport master (
      output lii_in_p0_tdata, lii_in_p0_tvalid,
      output lii_in_p0_src, lii_in_p0_dst,
      input  lii_in_p0_tready,
      input  out_tdata, out_tvalid, out_src, drop_cnt,
      output out_tready
   );

   modport slave (
      input  lii_in_p0_tdata, lii_in_p0_tvalid,
      input  lii_in_p0_src, lii_in_p0_dst,
      output lii_in_p0_tready,
      output out_tdata, out_tvalid, out_src, drop_cnt,
      input  out_tready
   );
endinterface

// File: rtl/lii_rx_demux.sv
// LII rx demux: hold register steers beats by dst into per-output FIFOs.
// Ports: aclk, arst (sync, active-high), lii (slave view of lii_rx_demux_if).
module lii_rx_demux #(
   parameter int         PW      = 128,
   parameter int         NOUT    = 2,
   parameter logic [7:0] BASE_ID = 8'h00,
   parameter int         DEPTH   = 4
) (
   input logic aclk,
   input logic arst,
   lii_rx_demux_if.slave lii
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int IW = (NOUT > 1) ? $clog2(NOUT) : 1;
   localparam int CW = AW + 1;

   logic            hold_v;
   logic            hold_bad;
   logic [PW-1:0]   hold_data;
   logic [7:0]      hold_src;
   logic [IW-1:0]   hold_idx;

   logic [7:0]      in_off;
   logic            in_bad;
   logic            tgt_full;
   logic            hold_go;
   logic            in_rdy;
   logic            acc;
   logic [15:0]     drop_q;

   logic [PW-1:0]   mem_d [NOUT][DEPTH];
   logic [7:0]      mem_s [NOUT][DEPTH];
   logic [AW-1:0]   wp    [NOUT];
   logic [AW-1:0]   rp    [NOUT];
   logic [CW-1:0]   cnt   [NOUT];

   logic [NOUT-1:0] full;
   logic [NOUT-1:0] vld;
   logic [NOUT-1:0] push;
   logic [NOUT-1:0] pop;

   assign in_off = lii.lii_in_p0_dst - BASE_ID;
   assign in_bad = (lii.lii_in_p0_dst < BASE_ID)
                 | ({1'b0, in_off} >= 9'(NOUT));

   always_comb begin
      tgt_full = 1'b0;
      full     = '0;
      vld      = '0;
      for (int i = 0; i < NOUT; i++) begin
         full[i] = (cnt[i] == CW'(DEPTH));
         vld[i]  = !arst && (cnt[i] != '0);
         if (hold_idx == IW'(i))
            tgt_full = full[i];
      end
   end

   // A bad beat always drains; a good one waits for room in its FIFO.
   assign hold_go = hold_v & (hold_bad | !tgt_full);
   // Registered-state only: never looks at tvalid.
   assign in_rdy  = !arst & (!hold_v | hold_go);
   assign acc     = in_rdy & lii.lii_in_p0_tvalid;

   always_comb begin
      push = '0;
      pop  = '0;
      for (int i = 0; i < NOUT; i++) begin
         push[i] = hold_go && !hold_bad && (hold_idx == IW'(i));
         pop[i]  = vld[i] && lii.out_tready[i];
      end
   end

   // Data is masked while empty so idle and reset outputs read as zero.
   always_comb begin
      lii.out_tdata = '0;
      lii.out_src   = '0;
      for (int i = 0; i < NOUT; i++) begin
         if (vld[i]) begin
            lii.out_tdata[i*PW +: PW] = mem_d[i][rp[i]];
            lii.out_src[i*8 +: 8]     = mem_s[i][rp[i]];
         end
      end
   end

   assign lii.lii_in_p0_tready = in_rdy;
   assign lii.out_tvalid       = vld;
   assign lii.drop_cnt         = drop_q;

   always_ff @(posedge aclk) begin
      if (arst) begin
         hold_v <= 1'b0;
         drop_q <= '0;
         for (int i = 0; i < NOUT; i++) begin
            wp[i]  <= '0;
            rp[i]  <= '0;
            cnt[i] <= '0;
         end
      end else begin
         if (acc)
            hold_v <= 1'b1;
         else if (hold_go)
            hold_v <= 1'b0;

         if (hold_go && hold_bad && drop_q != 16'hFFFF)
            drop_q <= drop_q + 16'd1;

         for (int i = 0; i < NOUT; i++) begin
            if (push[i])
               wp[i] <= wp[i] + 1'b1;
            if (pop[i])
               rp[i] <= rp[i] + 1'b1;
            case ({push[i], pop[i]})
               2'b10:   cnt[i] <= cnt[i] + 1'b1;
               2'b01:   cnt[i] <= cnt[i] - 1'b1;
               default: cnt[i] <= cnt[i];
            endcase
         end
      end
   end

   // Payload storage carries no reset; validity lives in hold_v and cnt.
   always_ff @(posedge aclk) begin
      if (acc) begin
         hold_data <= lii.lii_in_p0_tdata;
         hold_src  <= lii.lii_in_p0_src;
         hold_idx  <= in_off[IW-1:0];
         hold_bad  <= in_bad;
      end
      for (int i = 0; i < NOUT; i++) begin
         if (push[i]) begin
            mem_d[i][wp[i]] <= hold_data;
            mem_s[i][wp[i]] <= hold_src;
         end
      end
   end
endmodule

// File: tb/tb_lii_rx_demux.sv
// Randomized scoreboard bench for lii_rx_demux.
// Driver feeds a queue model; a negedge monitor pops and compares.
module tb_lii_rx_demux;
   localparam int         PW    = 128;
   localparam int         NOUT  = 2;
   localparam int         DEPTH = 4;
   localparam logic [7:0] BASE  = 8'h10;

   typedef struct packed {
      logic [PW-1:0] d;
      logic [7:0]    s;
   } ent_t;

   logic aclk;
   logic arst;
   int   checks;
   int   errors;
   int   drops;
   bit   rnd_rdy;
   logic [NOUT-1:0] rdy_fixed;

   ent_t expq [NOUT][$];
   bit            prev_hold [NOUT];
   logic [PW-1:0] prev_d    [NOUT];
   logic [7:0]    prev_s    [NOUT];

   lii_rx_demux_if #(.PW(PW), .NOUT(NOUT)) bus ();

   lii_rx_demux #(
      .PW(PW), .NOUT(NOUT), .BASE_ID(BASE), .DEPTH(DEPTH)
   ) dut (
      .aclk(aclk),
      .arst(arst),
      .lii (bus)
   );

   initial aclk = 1'b0;
   always #5 aclk = ~aclk;

   task automatic chk(input string nm, input logic [127:0] act,
                      input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
      end
   endtask

   // Readies change only just after a rising edge.
   initial begin
      bus.out_tready = '0;
      forever begin
         @(posedge aclk);
         #1;
         if (rnd_rdy)
            bus.out_tready = NOUT'($urandom);
         else
            bus.out_tready = rdy_fixed;
      end
   end

   // Reference model: mapped beats queue per output, others are dropped.
   task automatic model(input logic [7:0] dst, input logic [7:0] src,
                        input logic [PW-1:0] d);
      int off;
      ent_t e;
      off = int'(dst) - int'(BASE);
      e.d = d;
      e.s = src;
      if (off >= 0 && off < NOUT)
         expq[off].push_back(e);
      else if (drops < 65535)
         drops++;
   endtask

   task automatic send(input logic [7:0] dst, input logic [7:0] src,
                       input logic [PW-1:0] d, output int waits);
      waits = 0;
      @(posedge aclk);
      #1;
      bus.lii_in_p0_tvalid = 1'b1;
      bus.lii_in_p0_dst    = dst;
      bus.lii_in_p0_src    = src;
      bus.lii_in_p0_tdata  = d;
      while (1) begin
         @(negedge aclk);
         if (bus.lii_in_p0_tready)
            break;
         waits++;
         if (waits > 300) begin
            checks++;
            errors++;
            $display("FAIL send_timeout act=%0d exp=accept", waits);
            return;
         end
         @(posedge aclk);
         #1;
      end
      model(dst, src, d);
   endtask

   task automatic idle();
      @(posedge aclk);
      #1;
      bus.lii_in_p0_tvalid = 1'b0;
   endtask

   function automatic int pending();
      int n = 0;
      for (int i = 0; i < NOUT; i++)
         n += expq[i].size();
      return n;
   endfunction

   function automatic logic [PW-1:0] rnd_data();
      return {$urandom, $urandom, $urandom, $urandom};
   endfunction

   task automatic drain(input string nm);
      int t = 0;
      idle();
      rdy_fixed = '1;
      while (pending() > 0 && t < 500) begin
         @(negedge aclk);
         t++;
      end
      chk({nm, "_left"}, 128'(pending()), 0);
      repeat (3) @(negedge aclk);
      chk({nm, "_valid"}, 128'(bus.out_tvalid), 0);
      chk({nm, "_drop"}, 128'(bus.drop_cnt), 128'(drops));
   endtask

   // Monitor: pops the model on each handshake and checks AXI stability.
   always @(negedge aclk) begin
      ent_t e;
      for (int i = 0; i < NOUT; i++) begin
         if (arst) begin
            prev_hold[i] = 1'b0;
         end else begin
            if (prev_hold[i]) begin
               chk("stable_valid", 128'(bus.out_tvalid[i]), 1);
               chk("stable_data", bus.out_tdata[i*PW +: PW], prev_d[i]);
               chk("stable_src", 128'(bus.out_src[i*8 +: 8]),
                   128'(prev_s[i]));
            end
            prev_hold[i] = bus.out_tvalid[i] && !bus.out_tready[i];
            prev_d[i]    = bus.out_tdata[i*PW +: PW];
            prev_s[i]    = bus.out_src[i*8 +: 8];
            if (bus.out_tvalid[i] && bus.out_tready[i]) begin
               if (expq[i].size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL pop_unexpected out%0d data=%0h exp=none",
                           i, bus.out_tdata[i*PW +: PW]);
               end else begin
                  e = expq[i].pop_front();
                  chk("out_data", bus.out_tdata[i*PW +: PW], e.d);
                  chk("out_src", 128'(bus.out_src[i*8 +: 8]), 128'(e.s));
               end
            end
         end
      end
   end

   initial begin
      int w;
      int wsum;
      int t;
      int r;
      logic [7:0] dst;

      checks    = 0;
      errors    = 0;
      drops     = 0;
      rnd_rdy   = 1'b0;
      rdy_fixed = '1;
      arst      = 1'b1;
      bus.lii_in_p0_tvalid = 1'b0;
      bus.lii_in_p0_tdata  = '0;
      bus.lii_in_p0_src    = '0;
      bus.lii_in_p0_dst    = '0;

      // Reset and idle
      repeat (3) @(negedge aclk);
      chk("rst_tready", 128'(bus.lii_in_p0_tready), 0);
      chk("rst_valid", 128'(bus.out_tvalid), 0);
      @(posedge aclk);
      #1;
      arst = 1'b0;
      @(negedge aclk);
      chk("post_rst_tready", 128'(bus.lii_in_p0_tready), 1);
      chk("post_rst_valid", 128'(bus.out_tvalid), 0);
      chk("post_rst_drop", 128'(bus.drop_cnt), 0);
      chk("post_rst_data", 128'(bus.out_tdata), 0);

      // First-beat latency
      send(8'h10, 8'h55, 128'd1, w);
      idle();
      @(negedge aclk);
      chk("lat_edge_n", 128'(bus.out_tvalid[0]), 0);
      @(negedge aclk);
      chk("lat_edge_n1", 128'(bus.out_tvalid[0]), 1);
      drain("lat");

      // Streaming back-to-back
      wsum = 0;
      for (int k = 1; k <= 4; k++) begin
         send((k % 2 == 1) ? 8'h10 : 8'h11, 8'(8'hA0 + k),
              128'(k), w);
         wsum += w;
      end
      chk("stream_waits", 128'(wsum), 0);
      drain("stream");

      // Backpressure on out0
      rdy_fixed = 2'b10;
      repeat (2) @(negedge aclk);
      wsum = 0;
      for (int k = 0; k < 5; k++) begin
         send(8'h10, 8'(8'hB0 + k), rnd_data(), w);
         wsum += w;
      end
      chk("bp_waits", 128'(wsum), 0);
      idle();
      repeat (3) @(negedge aclk);
      chk("bp_tready", 128'(bus.lii_in_p0_tready), 0);
      chk("bp_valid0", 128'(bus.out_tvalid[0]), 1);
      rdy_fixed = '1;
      send(8'h10, 8'hB5, rnd_data(), w);
      drain("bp");

      // Unmapped destinations
      wsum = 0;
      send(8'h0F, 8'h01, rnd_data(), w);
      wsum += w;
      send(8'h12, 8'h02, rnd_data(), w);
      wsum += w;
      send(8'hFF, 8'h03, rnd_data(), w);
      wsum += w;
      idle();
      repeat (3) @(negedge aclk);
      chk("bad_waits", 128'(wsum), 0);
      chk("bad_drop", 128'(bus.drop_cnt), 3);
      chk("bad_valid", 128'(bus.out_tvalid), 0);

      // Isolation: out1 stalled and full, out0 keeps flowing
      rdy_fixed = 2'b01;
      repeat (2) @(negedge aclk);
      for (int k = 0; k < DEPTH; k++)
         send(8'h11, 8'(8'hC0 + k), rnd_data(), w);
      wsum = 0;
      for (int k = 0; k < 3; k++) begin
         send(8'h10, 8'(8'hD0 + k), rnd_data(), w);
         wsum += w;
      end
      chk("iso_flow_waits", 128'(wsum), 0);
      send(8'h11, 8'hCF, rnd_data(), w);
      idle();
      for (int k = 0; k < 3; k++) begin
         @(negedge aclk);
         chk("iso_blocked", 128'(bus.lii_in_p0_tready), 0);
      end
      chk("iso_valid1", 128'(bus.out_tvalid[1]), 1);
      rdy_fixed = '1;
      t = 0;
      while (!bus.lii_in_p0_tready && t < 20) begin
         @(negedge aclk);
         t++;
      end
      chk("iso_release", 128'(bus.lii_in_p0_tready), 1);
      drain("iso");

      // Randomized traffic with random readies
      rnd_rdy = 1'b1;
      for (int k = 0; k < 400; k++) begin
         r = $urandom_range(0, 9);
         if (r < 4)
            dst = 8'h10;
         else if (r < 8)
            dst = 8'h11;
         else if (r == 8)
            dst = ($urandom_range(0, 1) == 0) ? 8'h0F : 8'h12;
         else
            dst = 8'($urandom);
         send(dst, 8'($urandom), rnd_data(), w);
      end
      rnd_rdy = 1'b0;
      drain("rand");

      // Mid-stream reset
      rdy_fixed = '0;
      repeat (2) @(negedge aclk);
      send(8'h10, 8'hE0, rnd_data(), w);
      send(8'h11, 8'hE1, rnd_data(), w);
      send(8'h10, 8'hE2, rnd_data(), w);
      idle();
      repeat (3) @(negedge aclk);
      chk("mr_buffered", 128'(bus.out_tvalid), 2'b11);
      @(posedge aclk);
      #1;
      arst = 1'b1;
      for (int i = 0; i < NOUT; i++)
         expq[i].delete();
      drops = 0;
      @(negedge aclk);
      chk("mr_in_rst_tready", 128'(bus.lii_in_p0_tready), 0);
      chk("mr_in_rst_valid", 128'(bus.out_tvalid), 0);
      @(posedge aclk);
      #1;
      arst = 1'b0;
      @(negedge aclk);
      chk("mr_valid", 128'(bus.out_tvalid), 0);
      chk("mr_drop", 128'(bus.drop_cnt), 0);
      chk("mr_tready", 128'(bus.lii_in_p0_tready), 1);
      rdy_fixed = '1;
      for (int k = 0; k < 4; k++)
         send(8'(8'h10 + (k % 2)), 8'(8'hF0 + k), rnd_data(), w);
      drain("mr");

      // Drop counter saturation
      for (int k = 0; k < 65540; k++)
         send(8'hFF, 8'h00, '0, w);
      idle();
      repeat (3) @(negedge aclk);
      chk("sat_drop", 128'(bus.drop_cnt), 128'h0000_FFFF);
      chk("sat_tready", 128'(bus.lii_in_p0_tready), 1);
      chk("sat_valid", 128'(bus.out_tvalid), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
